// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sequencer
// Description : Pipeline hazard control for a 5-stage F/D/E/M/W core.
//               Produces operand-forwarding selects, load-use stalls,
//               branch/PC-write flushes, and sequences multi-cycle execute
//               operations. While a multi-cycle op runs, it holds F/D/E and
//               inserts bubbles into M.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sequencer #(
  parameter  int MUL_CYCLES = 4,
  localparam int CW         = $clog2(MUL_CYCLES)
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchE,
  input  logic       MulStartE,
  input  logic       CondExE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       BranchTakenE,
  output logic       MulBusy,
  output logic       MulDoneE
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The mulgo cycle itself is the first E cycle, so BUSY lasts MUL_CYCLES-1
  // cycles and the counter starts at MUL_CYCLES-2 to end on zero.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_CYCLES - 2);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  logic ldrstall;
  logic pcpend;
  logic mulgo;
  logic mulhold;
  logic branch_taken;

  // Predicated-off multiplies never start the sequencer; a second start is
  // ignored while BUSY so a held MulStartE cannot retrigger.
  assign mulgo        = MulStartE & CondExE & (state == IDLE);
  assign mulhold      = mulgo | ((state == BUSY) & (cnt != '0));
  assign branch_taken = BranchE & CondExE;
  assign ldrstall     = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pcpend       = PCSrcD | PCSrcE | PCSrcM;

  // State and occupancy counter register; reset returns to IDLE at once.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic for the multi-cycle sequencer.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (mulgo) begin
          state_next = BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Operand forwarding: the younger result in M wins over the one in W.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RA1E == WA3M))      ForwardAE = 2'b10;
    else if (RegWriteW && (RA1E == WA3W)) ForwardAE = 2'b01;
    if (RegWriteM && (RA2E == WA3M))      ForwardBE = 2'b10;
    else if (RegWriteW && (RA2E == WA3W)) ForwardBE = 2'b01;
  end

  // Stall/flush outputs; a multiply hold suppresses the load-use bubble so
  // the load-use check is re-evaluated after the hold releases.
  always_comb begin
    StallF       = ldrstall | pcpend | mulhold;
    StallD       = ldrstall | mulhold;
    StallE       = mulhold;
    FlushD       = pcpend | PCSrcW | branch_taken;
    FlushE       = (ldrstall | branch_taken) & ~mulhold;
    FlushM       = mulhold;
    BranchTakenE = branch_taken;
    MulBusy      = (state == BUSY);
    MulDoneE     = (state == BUSY) & (cnt == '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_sequencer
// Description : Self-checking bench for hazard_sequencer: directed scenarios
//               followed by random stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_sequencer;

  localparam int MUL_CYCLES = 4;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic       BranchE, MulStartE, CondExE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic       BranchTakenE, MulBusy, MulDoneE;

  int vectors = 0;
  int errors  = 0;

  // Model state: BUSY cycles of the current multiply still ahead (0 = idle).
  int busy_left = 0;

  hazard_sequencer #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .CLK(CLK), .Reset(Reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchE(BranchE), .MulStartE(MulStartE), .CondExE(CondExE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .BranchTakenE(BranchTakenE), .MulBusy(MulBusy), .MulDoneE(MulDoneE)
  );

  always #5 CLK = ~CLK;

  // A multiply and a branch in E together is not a legal instruction mix.
  always @(negedge CLK) begin
    if (!Reset) assert (!(MulStartE && BranchE)) else $error("FAIL illegal MulStartE&BranchE driven");
  end

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [3:0] ra);
    if (RegWriteM && ra == WA3M) return 2'b10;
    if (RegWriteW && ra == WA3W) return 2'b01;
    return 2'b00;
  endfunction

  // Compare every output with what the pipeline rules demand right now.
  task automatic check_model();
    logic ld, pc, bt, go, hold;
    ld   = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
    pc   = PCSrcD || PCSrcE || PCSrcM;
    bt   = BranchE && CondExE;
    go   = MulStartE && CondExE && busy_left == 0 && !Reset;
    hold = go || busy_left > 1;
    chk("m_fwdA",   ForwardAE, fwd(RA1E));
    chk("m_fwdB",   ForwardBE, fwd(RA2E));
    chk("m_stallF", {1'b0, StallF}, {1'b0, ld || pc || hold});
    chk("m_stallD", {1'b0, StallD}, {1'b0, ld || hold});
    chk("m_stallE", {1'b0, StallE}, {1'b0, hold});
    chk("m_flushD", {1'b0, FlushD}, {1'b0, pc || PCSrcW || bt});
    chk("m_flushE", {1'b0, FlushE}, {1'b0, (ld || bt) && !hold});
    chk("m_flushM", {1'b0, FlushM}, {1'b0, hold});
    chk("m_btaken", {1'b0, BranchTakenE}, {1'b0, bt});
    chk("m_busy",   {1'b0, MulBusy}, {1'b0, busy_left != 0});
    chk("m_done",   {1'b0, MulDoneE}, {1'b0, busy_left == 1});
  endtask

  // Advance one clock and the model with it; inputs change 1 time unit later.
  task automatic tick();
    logic go;
    go = MulStartE && CondExE && busy_left == 0;
    @(posedge CLK);
    if (Reset)              busy_left = 0;
    else if (busy_left > 0) busy_left--;
    else if (go)            busy_left = MUL_CYCLES - 1;
    #1;
  endtask

  task automatic step();
    #1;
    check_model();
    tick();
  endtask

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E} = '0;
    WA3E = 4'd14; WA3M = 4'd13; WA3W = 4'd12;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW} = '0;
    {BranchE, MulStartE, CondExE} = '0;
  endtask

  initial begin
    clear_inputs();
    Reset = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    busy_left = 0;
    chk("rst_busy",  {1'b0, MulBusy}, 2'b00);
    chk("rst_stallE", {1'b0, StallE}, 2'b00);
    chk("rst_flushM", {1'b0, FlushM}, 2'b00);
    Reset = 1'b0;
    tick();

    // Forwarding from M, from W, and M priority on a shared register.
    RA1E = 4'd1; WA3M = 4'd1; RegWriteM = 1'b1; #1;
    chk("fwdA_M", ForwardAE, 2'b10);
    chk("fwdB_M0", ForwardBE, 2'b00);
    step();
    WA3M = 4'd3; WA3W = 4'd1; RegWriteW = 1'b1; #1;
    chk("fwdA_W", ForwardAE, 2'b01);
    step();
    RA2E = 4'd5; WA3M = 4'd5; WA3W = 4'd5; #1;
    chk("fwdB_Mpri", ForwardBE, 2'b10);
    step();
    RA1E = 4'd15; WA3M = 4'd15; #1;
    chk("fwdA_r15", ForwardAE, 2'b10);
    step();
    clear_inputs();

    // Load-use: one stall cycle, then the load has moved to M.
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA1D = 4'd2; #1;
    chk("ldr_stallF", {1'b0, StallF}, 2'b01);
    chk("ldr_stallD", {1'b0, StallD}, 2'b01);
    chk("ldr_flushE", {1'b0, FlushE}, 2'b01);
    step();
    MemtoRegE = 1'b0; RegWriteE = 1'b0; WA3M = 4'd2; RegWriteM = 1'b1; RA1E = 4'd2; #1;
    chk("ldr_release", {1'b0, StallD}, 2'b00);
    chk("ldr_fwd", ForwardAE, 2'b10);
    step();
    clear_inputs();

    // Taken and not-taken branch.
    BranchE = 1'b1; CondExE = 1'b1; #1;
    chk("br_taken", {BranchTakenE, FlushE}, 2'b11);
    chk("br_flushD", {1'b0, FlushD}, 2'b01);
    step();
    CondExE = 1'b0; #1;
    chk("br_nt", {BranchTakenE, FlushE}, 2'b00);
    chk("br_nt_fD", {1'b0, FlushD}, 2'b00);
    step();
    clear_inputs();

    // PC write walking D -> W: StallF for 3 cycles, FlushD for 4.
    for (int s = 0; s < 5; s++) begin
      PCSrcD = (s == 0); PCSrcE = (s == 1); PCSrcM = (s == 2); PCSrcW = (s == 3); #1;
      chk($sformatf("pc_stallF%0d", s), {1'b0, StallF}, {1'b0, s < 3});
      chk($sformatf("pc_flushD%0d", s), {1'b0, FlushD}, {1'b0, s < 4});
      step();
    end
    clear_inputs();

    // Multiply at t with a concurrent load-use in D; MulStartE stays high.
    MulStartE = 1'b1; CondExE = 1'b1;
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd7; RA2D = 4'd7;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("mul_stallE_t%0d", c), {1'b0, StallE}, {1'b0, c < 3});
      chk($sformatf("mul_flushM_t%0d", c), {1'b0, FlushM}, {1'b0, c < 3});
      chk($sformatf("mul_busy_t%0d", c),   {1'b0, MulBusy}, {1'b0, c >= 1 && c <= 3});
      chk($sformatf("mul_done_t%0d", c),   {1'b0, MulDoneE}, {1'b0, c == 3});
      chk($sformatf("mul_flushE_t%0d", c), {1'b0, FlushE}, {1'b0, c >= 3});
      if (c == 3) MulStartE = 1'b0;
      tick();
    end
    clear_inputs();

    // Predicated-off multiply never sequences.
    MulStartE = 1'b1; CondExE = 1'b0;
    step();
    #1;
    chk("mul_nocond", {1'b0, MulBusy}, 2'b00);
    step();
    clear_inputs();

    // Reset one cycle into a multiply.
    MulStartE = 1'b1; CondExE = 1'b1;
    step();
    clear_inputs();
    Reset = 1'b1; #1;
    chk("rst_mid_busy",   {1'b0, MulBusy}, 2'b00);
    chk("rst_mid_stallE", {1'b0, StallE}, 2'b00);
    tick();
    Reset = 1'b0;
    step();
    #1;
    chk("rst_after_idle", {1'b0, MulBusy}, 2'b00);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      RA1D = 4'($urandom_range(0, 3)); RA2D = 4'($urandom_range(0, 3));
      RA1E = 4'($urandom_range(0, 3)); RA2E = 4'($urandom_range(0, 3));
      WA3E = 4'($urandom_range(0, 3)); WA3M = 4'($urandom_range(0, 3));
      WA3W = 4'($urandom_range(0, 3));
      RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemtoRegE = 1'($urandom);
      PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
      PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
      CondExE = 1'($urandom);
      MulStartE = ($urandom_range(0, 4) == 0);
      BranchE = MulStartE ? 1'b0 : ($urandom_range(0, 3) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Hard time bound so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
